// File: rtl/fc_cmd_queue.sv
// Frame-counter command queue: FIFO of frame budgets metered out to the frame gate.
// Optional FC_UNDERRUN_CNT_EN builds a saturating count of frames completed while idle.
module fc_cmd_queue #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_W-1:0]     cmd_data,
  input  logic                  cmd_valid,
  input  logic                  frame_done,
  output logic                  gate_open,
  output logic [DATA_W-1:0]     budget,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  fc_overflow,
  output logic [15:0]           underrun_count,
  output logic                  state_dbg
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  // Handshake: cmd_valid is a one-cycle strobe with no ready; a command that
  // finds the FIFO full (and no pop in the same cycle) is dropped and flagged
  // by fc_overflow on the following cycle.

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     budget_q, budget_d;
  logic                  gate_open_q, gate_open_d;
  logic                  overflow_q, overflow_d;
  logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DATA_W-1:0]     head;
  logic [DEPTH_LOG2:0]   count;
  logic                  empty, full;
  logic                  pop, push;

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);
  assign head  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  // State register and FIFO storage.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      budget_q    <= '0;
      gate_open_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      budget_q    <= budget_d;
      gate_open_q <= gate_open_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= cmd_data;
    end
  end

  // Next-state: the FSM alone decides when to pop, so pop-on-empty cannot occur.
  always_comb begin
    state_d  = state_q;
    budget_d = budget_q;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          budget_d = head;
          if (head != '0) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (frame_done) begin
          if (budget_q > DATA_W'(1)) begin
            budget_d = budget_q - DATA_W'(1);
          end else if (empty) begin
            budget_d = '0;
            state_d  = S_IDLE;
          end else begin
            // Chain straight into the next command so the gate never blinks.
            pop      = 1'b1;
            budget_d = head;
            if (head == '0) state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        budget_d = '0;
      end
    endcase
  end

  always_comb begin
    push        = cmd_valid && (!full || pop);
    overflow_d  = cmd_valid && full && !pop;
    wr_ptr_d    = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, push};
    rd_ptr_d    = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, pop};
    gate_open_d = (budget_d != '0);
  end

`ifdef FC_UNDERRUN_CNT_EN
  logic [15:0] underrun_q, underrun_d;

  always_comb begin
    underrun_d = underrun_q;
    if (frame_done && (state_q == S_IDLE) && (underrun_q != 16'hFFFF)) begin
      underrun_d = underrun_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) underrun_q <= '0;
    else         underrun_q <= underrun_d;
  end

  assign underrun_count = underrun_q;
`else
  assign underrun_count = 16'h0000;
`endif

  // Output process.
  always_comb begin
    gate_open   = gate_open_q;
    budget      = budget_q;
    fifo_count  = count;
    fifo_empty  = empty;
    fifo_full   = full;
    fc_overflow = overflow_q;
    state_dbg   = (state_q == S_RUN);
  end

endmodule

// File: doc/fc_cmd_queue.md
Name: fc_cmd_queue

Overview:
- Frame-counter command queue. It buffers frame-budget commands from the host/control path in a FIFO and meters them out to the frame gate.
- Each command is a number of frames the gate may pass. The block counts frame completions against the active budget.
- It pulses fc_overflow when a command arrives while the FIFO cannot accept it. That pulse feeds status_mgr, which latches it and drives the error LED.

Parameters:
- DATA_W, 32, width of a command (frame budget) and of the budget counter.
- DEPTH_LOG2, 4, log2 of FIFO depth; depth is 2**DEPTH_LOG2 entries (16 by default).

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- resetn  input  1  reset: synchronous, active-low.
- cmd_data  input  DATA_W  frame-budget command.
- cmd_valid  input  1  single-cycle write strobe for cmd_data. There is no ready/backpressure.
- frame_done  input  1  single-cycle pulse, one per completed frame.
- gate_open  output  1  high while the active budget is nonzero.
- budget  output  DATA_W  frames remaining in the active command.
- fifo_count  output  DEPTH_LOG2+1  number of queued commands, 0..2**DEPTH_LOG2.
- fifo_empty  output  1  fifo_count == 0.
- fifo_full  output  1  fifo_count == 2**DEPTH_LOG2.
- fc_overflow  output  1  one-cycle pulse on each dropped command.
- underrun_count  output  16  frames completed while the gate was closed; see Optional Feature.

Behaviour:
- Reset values (synchronous, resetn==0):
  - FIFO pointers 0, fifo_count 0, fifo_empty 1, fifo_full 0.
  - budget 0, gate_open 0, fc_overflow 0, underrun_count 0.
  - FSM in IDLE.
  - Reset asserted mid-operation flushes queued commands and aborts the active budget. No overflow pulse is generated during reset.
- FIFO:
  - Circular buffer of 2**DEPTH_LOG2 x DATA_W with DEPTH_LOG2+1-bit read and write pointers; pointers wrap naturally.
  - Write is accepted when cmd_valid && (!fifo_full || pop_this_cycle). A pop in the same cycle frees the slot.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Pop on empty never occurs; the FSM guarantees it.
  - Head data is read combinationally from the memory at the read pointer.
- Overflow:
  - When cmd_valid && fifo_full && !pop_this_cycle, the command is dropped and fc_overflow goes high for exactly one cycle on the next clock.
  - Consecutive drops produce consecutive high cycles.
- FSM states: IDLE and RUN.
  - IDLE:
    - If !fifo_empty, pop the head and set budget <= head.
    - Go to RUN if head != 0. If head == 0, the command is discarded and the FSM stays in IDLE; the next command is examined the following cycle.
    - frame_done is ignored, apart from the underrun counter.
  - RUN:
    - On frame_done with budget > 1: budget <= budget - 1.
    - On frame_done with budget == 1 and fifo_empty: budget <= 0, go to IDLE.
    - On frame_done with budget == 1 and !fifo_empty: pop and load budget <= head in the same cycle.
      - If head != 0, stay in RUN; the gate stays open, with no bubble between commands.
      - If head == 0, budget <= 0 and go to IDLE.
    - No frame_done: hold.
- gate_open is registered and equals (budget != 0) with the same timing as budget.
- Latency: cmd_valid at edge N into an empty, idle queue makes fifo_count 1 after N. IDLE pops at N+1, and budget/gate_open are valid after edge N+1, i.e. visible in cycle N+2.
- budget never decrements below 0. frame_done on the same cycle as a load in IDLE is not applied to the new budget.

Optional Feature:
- Macro: FC_UNDERRUN_CNT_EN.
- Defined: underrun_count increments on each frame_done received while FSM is IDLE. It is 16-bit and saturates at 16'hFFFF. It is cleared only by reset.
- Not defined: no counter logic is built and underrun_count is tied to 0.

Test Plan:
- Single command: write cmd 3, then 3 frame_done pulses spaced 5 cycles apart -> gate_open rises 2 cycles after cmd_valid; budget steps 3,2,1,0; gate_open falls the cycle after the 3rd pulse; FSM returns to IDLE.
- Back-to-back commands: queue 2 then 4, apply 6 frame_done pulses -> budget sequence 2,1,4,3,2,1,0; gate_open never drops between commands; fifo_count goes 2,1,0.
- Overflow: with FSM in RUN (budget 100), write 17 commands with DEPTH_LOG2=4 -> fifo_full after the 16th; the 17th is dropped; fc_overflow is high for exactly 1 cycle; fifo_count stays 16.
- Full push+pop: fifo_full, budget 1, frame_done and cmd_valid in the same cycle -> write accepted, no fc_overflow, fifo_count stays 16, budget loads the head value.
- Zero command and reset: queue 0 then 5 -> the 0 is discarded; budget becomes 5 one cycle later. Assert resetn=0 mid-run -> budget 0, gate_open 0, fifo_count 0 after the reset edge.
- With FC_UNDERRUN_CNT_EN: 3 frame_done pulses in IDLE -> underrun_count 3. Force 70000 pulses -> underrun_count saturates at 65535. Without the macro, underrun_count stays 0.
